// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// ---------------------------------------------------------------------------
// One register slot between two processor pipeline stages. It carries the
// instruction word, PC, branch-delay flag, merged exception code, a Tnew
// countdown and a generic payload. It also counts how long the slot has been
// held by consecutive stalls.
//
// Every rising edge performs exactly one action. The priority is
// reset > req > flush > stall > load:
//   reset : out_pc = RESET_PC, every other output cleared
//   req   : out_pc = HANDLER_PC, every other output cleared
//   flush : bubble; payload fields cleared, but out_pc/out_bd follow the inputs
//   stall : everything held, out_hold_cnt increments and saturates at 0xFF
//   load  : capture inputs; the older exception wins; Tnew optionally counts down
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   req, flush, stall pipeline control (exception request, bubble, hold)
//   in_valid, in_instr, in_pc, in_bd, in_exc, in_exc_new, in_tnew, in_payload
//                     upstream slot contents
//   out_valid, out_instr, out_pc, out_bd, out_exc, out_tnew, out_payload
//                     registered slot contents
//   out_hold_cnt      consecutive stall cycles, saturating at 0xFF
//
// Every output comes straight from a flop, so no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int          DATA_W     = 32,
    parameter int          TNEW_W     = 4,
    parameter int          TNEW_DEC   = 1,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    input  logic              in_bd,
    input  logic [4:0]        in_exc,
    input  logic [4:0]        in_exc_new,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic [DATA_W-1:0] in_payload,
    output logic              out_valid,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic              out_bd,
    output logic [4:0]        out_exc,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [DATA_W-1:0] out_payload,
    output logic [7:0]        out_hold_cnt
);

    // Tnew on load: count down toward 0 and never wrap, or pass through
    // unchanged when the stage does not consume a cycle of latency.
    function automatic logic [TNEW_W-1:0] tnew_on_load(input logic [TNEW_W-1:0] t);
        if (TNEW_DEC == 0) begin
            return t;
        end else if (t == '0) begin
            return '0;
        end else begin
            return t - TNEW_W'(1);
        end
    endfunction

    // The stall counter saturates, so a very long stall still reads as "long".
    function automatic logic [7:0] hold_sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? 8'hFF : c + 8'd1;
    endfunction

    // An exception raised in an earlier stage is older than one detected
    // upstream this cycle, so it takes precedence.
    function automatic logic [4:0] exc_merge(input logic [4:0] older, input logic [4:0] newer);
        return (older != 5'd0) ? older : newer;
    endfunction

    logic              valid_q,   valid_d;
    logic [31:0]       instr_q,   instr_d;
    logic [31:0]       pc_q,      pc_d;
    logic              bd_q,      bd_d;
    logic [4:0]        exc_q,     exc_d;
    logic [TNEW_W-1:0] tnew_q,    tnew_d;
    logic [DATA_W-1:0] payload_q, payload_d;
    logic [7:0]        hold_q,    hold_d;

    always_comb begin
        // Default to holding, which is also the stall behaviour.
        valid_d   = valid_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        bd_d      = bd_q;
        exc_d     = exc_q;
        tnew_d    = tnew_q;
        payload_d = payload_q;
        hold_d    = hold_q;

        if (reset) begin
            valid_d   = 1'b0;
            instr_d   = '0;
            pc_d      = RESET_PC;
            bd_d      = 1'b0;
            exc_d     = '0;
            tnew_d    = '0;
            payload_d = '0;
            hold_d    = '0;
        end else if (req) begin
            valid_d   = 1'b0;
            instr_d   = '0;
            pc_d      = HANDLER_PC;
            bd_d      = 1'b0;
            exc_d     = '0;
            tnew_d    = '0;
            payload_d = '0;
            hold_d    = '0;
        end else if (flush) begin
            // The bubble keeps PC/BD so that an exception taken on it
            // still reports a meaningful EPC.
            valid_d   = 1'b0;
            instr_d   = '0;
            pc_d      = in_pc;
            bd_d      = in_bd;
            exc_d     = '0;
            tnew_d    = '0;
            payload_d = '0;
            hold_d    = '0;
        end else if (stall) begin
            hold_d    = hold_sat_inc(hold_q);
        end else begin
            valid_d   = in_valid;
            instr_d   = in_instr;
            pc_d      = in_pc;
            bd_d      = in_bd;
            exc_d     = exc_merge(in_exc, in_exc_new);
            tnew_d    = tnew_on_load(in_tnew);
            payload_d = in_payload;
            hold_d    = '0;
        end
    end

    // Stage boundary: upstream slot -> registered slot
    always_ff @(posedge clk) begin
        valid_q   <= valid_d;
        instr_q   <= instr_d;
        pc_q      <= pc_d;
        bd_q      <= bd_d;
        exc_q     <= exc_d;
        tnew_q    <= tnew_d;
        payload_q <= payload_d;
        hold_q    <= hold_d;
    end

    assign out_valid    = valid_q;
    assign out_instr    = instr_q;
    assign out_pc       = pc_q;
    assign out_bd       = bd_q;
    assign out_exc      = exc_q;
    assign out_tnew     = tnew_q;
    assign out_payload  = payload_q;
    assign out_hold_cnt = hold_q;

endmodule
